// File: rtl/demux_reg.sv
// demux_reg: registered 1-to-2 stream demultiplexer with valid/ready handshakes.
// Each input word is steered by `sel` into one of two one-entry output slots.
// Each slot drains independently, and a slot may drain and refill in the same cycle.
// Optional feature macro: DEMUX_REG_CNT_EN builds the per-channel delivery counters;
// without it, cnt0/cnt1 are tied to zero.
module demux_reg #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic drain0;
  logic drain1;
  logic accept0;
  logic accept1;

  // Ready is driven by the selected slot only and never looks at in_valid.
  always_comb begin
    in_ready = sel ? (~out1_valid | out1_ready) : (~out0_valid | out0_ready);
    drain0   = out0_valid & out0_ready;
    drain1   = out1_valid & out1_ready;
    accept0  = in_valid & in_ready & ~sel;
    accept1  = in_valid & in_ready &  sel;
  end

  // Channel 0 slot: an accept (re)loads it, and a drain with no refill empties it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out0_valid <= 1'b0;
      out0_data  <= '0;
    end else if (accept0) begin
      out0_valid <= 1'b1;
      out0_data  <= in_data;
    end else if (drain0) begin
      out0_valid <= 1'b0;
    end
  end

  // Channel 1 slot: same behaviour as channel 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      out1_valid <= 1'b0;
      out1_data  <= '0;
    end else if (accept1) begin
      out1_valid <= 1'b1;
      out1_data  <= in_data;
    end else if (drain1) begin
      out1_valid <= 1'b0;
    end
  end

`ifdef DEMUX_REG_CNT_EN
  // Delivery counters: each counts its own channel's output handshakes and wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (drain0) cnt0 <= cnt0 + 1'b1;
      if (drain1) cnt1 <= cnt1 + 1'b1;
    end
  end
`else
  // No counters are built in this configuration.
  always_comb begin
    cnt0 = '0;
    cnt1 = '0;
  end
`endif

endmodule
